// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed/unsigned operands
// with divide-by-zero and signed-overflow flags behind a start/done handshake.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             of
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] dmag_r;
   logic             neg_q_r;
   logic             neg_r_r;
   logic             ovf_r;

   logic             accept_s;
   logic             zero_div_s;
   logic [WIDTH:0]   pw_s;
   logic [WIDTH+1:0] trial_s;
   logic             borrow_s;
   logic [WIDTH-1:0] p_next_s;
   logic [WIDTH-1:0] q_next_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      magnitude = (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      apply_sign = neg ? (~v + ONE_W) : v;
   endfunction

   // Next-state decode and start acceptance.
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      zero_div_s = (divisor == {WIDTH{1'b0}});
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               accept_s = 1'b1;
               state_s  = zero_div_s ? DONE : RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // One restoring step; the shifted remainder keeps its top bit so large unsigned divisors work.
   always_comb begin
      pw_s     = {p_r, q_r[WIDTH-1]};
      trial_s  = {1'b0, pw_s} - {2'b00, dmag_r};
      // pw < 2*|divisor|, so bit WIDTH of a non-borrowing difference is always zero
      borrow_s = trial_s[WIDTH+1] | trial_s[WIDTH];
      if (borrow_s) begin
         p_next_s = pw_s[WIDTH-1:0];
      end else begin
         p_next_s = trial_s[WIDTH-1:0];
      end
      q_next_s = {q_r[WIDTH-2:0], ~borrow_s};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture and iteration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CW{1'b0}};
         p_r     <= {WIDTH{1'b0}};
         q_r     <= {WIDTH{1'b0}};
         dmag_r  <= {WIDTH{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept_s) begin
         cnt_r   <= CNT_TOP;
         p_r     <= {WIDTH{1'b0}};
         q_r     <= magnitude(dividend, is_signed);
         dmag_r  <= magnitude(divisor, is_signed);
         neg_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r_r <= is_signed & dividend[WIDTH-1];
         ovf_r   <= is_signed && (dividend == MIN_INT) && (divisor == {WIDTH{1'b1}});
      end else if (state_r == RUN) begin
         cnt_r <= cnt_r - CNT_ONE;
         p_r   <= p_next_s;
         q_r   <= q_next_s;
      end
   end

   // Registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= {WIDTH{1'b0}};
         remainder   <= {WIDTH{1'b0}};
         div_by_zero <= 1'b0;
         of          <= 1'b0;
      end else begin
         busy <= (state_s == RUN);
         done <= (state_r == DONE);
         if (accept_s && zero_div_s) begin
            quotient    <= {WIDTH{1'b1}};
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            of          <= 1'b0;
         end else if (accept_s) begin
            div_by_zero <= 1'b0;
            of          <= 1'b0;
         end else if ((state_r == RUN) && (cnt_r == {CW{1'b0}})) begin
            quotient    <= apply_sign(q_next_s, neg_q_r);
            remainder   <= apply_sign(p_next_s, neg_r_r);
            div_by_zero <= 1'b0;
            of          <= ovf_r;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations push expectations, a monitor
// pops and compares on every done pulse, including latency from the accepting edge.
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         of;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .of(of)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   int busy_cnt = 0;

   logic [W-1:0] eq_q[$];
   logic [W-1:0] er_q[$];
   logic         edz_q[$];
   logic         eof_q[$];
   int           elat_q[$];
   int           acc_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            if (eq_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: done seen at cycle %0d with nothing outstanding", cyc);
            end else begin
               check("quotient", quotient, eq_q.pop_front());
               check("remainder", remainder, er_q.pop_front());
               check("div_by_zero", div_by_zero, edz_q.pop_front());
               check("of", of, eof_q.pop_front());
               check("latency", cyc - acc_q.pop_front(), elat_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input logic eof, input int lat, input bit push, input bit sync);
      if (sync) @(negedge clk);
      dividend  = a;
      divisor   = b;
      is_signed = sgn;
      start     = 1'b1;
      if (push) begin
         eq_q.push_back(eq);
         er_q.push_back(er);
         edz_q.push_back(edz);
         eof_q.push_back(eof);
         elat_q.push_back(lat);
      end
      @(posedge clk);
      #1;
      if (push) acc_q.push_back(cyc);
      busy_cnt = 0;
      start    = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      dcyc = -1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dcyc = cyc;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 100 clocks");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_quotient"}, quotient, 0);
      check({tag, "_remainder"}, remainder, 0);
      check({tag, "_div_by_zero"}, div_by_zero, 0);
      check({tag, "_of"}, of, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int d1;
      int d2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // unsigned basic, latency and busy length
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);
      #1;
      check("busy_cycles", busy_cnt, 32);

      // signed sign rules
      issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);
      issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);
      issue(32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);

      // signed overflow and the same operands unsigned
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1, 33, 1'b1, 1'b1);
      wait_done(d1);
      issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);

      // divide by zero in both modes
      issue(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      wait_done(d1);
      issue(32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      wait_done(d1);

      // flags clear on accept, results held until the next done
      issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      check("dz_cleared_on_start", div_by_zero, 0);
      check("quotient_held", quotient, 32'hFFFFFFFF);
      repeat (3) begin
         @(negedge clk);
         dividend = 32'd5;
         divisor  = 32'd1;
         start    = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done(d1);
      // back-to-back: start asserted in the done cycle
      issue(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 33, 1'b1, 1'b0);
      check("back_to_back_gap", acc_q[acc_q.size()-1] - d1, 1);
      wait_done(d2);

      // reset in the 10th RUN cycle aborts with no done
      issue(32'h0000DEAD, 32'd3, 1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         #1;
         if (busy_cnt >= 10) break;
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("idle_after_abort", busy, 0);

      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 33, 1'b1, 1'b1);
      wait_done(d1);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", eq_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
